rf_multiport: RTL and testbench

Parametrised multi-port integer register file for the RV32I core. It supersedes the fixed 2-read/1-write file and adds configurable read/write port counts and a deterministic sequential clear engine that zeroes the array after reset or on request. An optional write-to-read bypass is also available. It sits between decode (read addresses) and writeback (write ports) and feeds operand muxes directly.

---
 rtl/rf_multiport_pkg.sv | 15 +
 rtl/rf_multiport_if.sv | 30 +++
 rtl/rf_multiport_read_port.sv | 42 ++++
 rtl/rf_multiport.sv | 93 +++++++++
 tb/tb_rf_multiport.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/rf_multiport_pkg.sv
// Shared RV32 definitions (package rv32_pkg) used by the register file slice.
package rv32_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [4:0] reg_addr_t;

    localparam int unsigned RF_ZERO_REG = 0;

    typedef enum logic [0:0] {
        RF_CLEAR,
        RF_RUN
    } rf_state_t;

endpackage

// File: rtl/rf_multiport_if.sv
// Register file access bus: read addresses/data, write ports, clear request and ready.
interface rf_multiport_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic                clr_req;
    logic                rdy;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   wa;
    logic [NWR*XLEN-1:0] wd;

    // Decode/writeback side
    modport master (
        output clr_req, ra, we, wa, wd,
        input  rdy, rd
    );

    // Register file side
    modport slave (
        input  clr_req, ra, we, wa, wd,
        output rdy, rd
    );

endinterface

// File: rtl/rf_multiport_read_port.sv
// One read port: address mux, zero-register masking and optional write bypass.
// Optional feature: RF_BYPASS_EN forwards same-cycle write data to matching reads.
module rf_read_port
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NWR   = 2,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic [AW-1:0]       addr,
    input  logic                rdy,
    input  logic [XLEN-1:0]     regs [NREGS],
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    output logic [XLEN-1:0]     data
);

`ifndef RF_BYPASS_EN
    // Write ports only matter when bypassing
    logic unused_bypass;
    assign unused_bypass = ^{we, wa, wd};
`endif

    // Stored value, overridden by same-cycle write data when bypass is built in
    always_comb begin
        data = '0;
        if (rdy && (addr != AW'(RF_ZERO_REG))) begin
            data = regs[addr];
`ifdef RF_BYPASS_EN
            // Later ports overwrite earlier ones, so the highest matching port wins
            for (int j = 0; j < int'(NWR); j++) begin
                if (we[j] && (wa[j*AW +: AW] == addr)) begin
                    data = wd[j*XLEN +: XLEN];
                end
            end
`endif
        end
    end

endmodule

// File: rtl/rf_multiport.sv
// Multi-port integer register file with sequential clear engine.
// Holds the array, the write decode and the CLEAR/RUN FSM.
// Optional feature: RF_BYPASS_EN (write-to-read bypass inside rf_read_port).
module rf_multiport
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN  = rv32_pkg::XLEN,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2
) (
    input logic           clk,
    input logic           rst_n,
    rf_multiport_if.slave bus
);

    localparam int unsigned AW = $clog2(NREGS);

    rf_state_t       state_q;
    logic [AW-1:0]   clr_idx_q;
    logic            rdy_q;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [NRD*XLEN-1:0] rd_vec;

    // Clear FSM: sweep indices 1..NREGS-1, then run until a clear request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= AW'(1);
            rdy_q     <= 1'b0;
        end else begin
            unique case (state_q)
                RF_CLEAR: begin
                    if (bus.clr_req) begin
                        clr_idx_q <= AW'(1);
                    end else if (clr_idx_q == AW'(NREGS - 1)) begin
                        // Terminal compare first, so the counter never wraps
                        state_q <= RF_RUN;
                        rdy_q   <= 1'b1;
                    end else begin
                        clr_idx_q <= clr_idx_q + AW'(1);
                    end
                end
                RF_RUN: begin
                    if (bus.clr_req) begin
                        state_q   <= RF_CLEAR;
                        clr_idx_q <= AW'(1);
                        rdy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= RF_CLEAR;
                    clr_idx_q <= AW'(1);
                    rdy_q     <= 1'b0;
                end
            endcase
        end
    end

    // Array update: clear sweep, or port writes (highest port last so it wins collisions)
    always_ff @(posedge clk) begin
        if (state_q == RF_CLEAR) begin
            regs_q[clr_idx_q] <= '0;
        end else if (!bus.clr_req) begin
            for (int j = 0; j < int'(NWR); j++) begin
                if (bus.we[j] && (bus.wa[j*AW +: AW] != AW'(RF_ZERO_REG))) begin
                    regs_q[bus.wa[j*AW +: AW]] <= bus.wd[j*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
        rf_read_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .NWR   (NWR),
            .AW    (AW)
        ) u_read_port (
            .addr (bus.ra[i*AW +: AW]),
            .rdy  (rdy_q),
            .regs (regs_q),
            .we   (bus.we),
            .wa   (bus.wa),
            .wd   (bus.wd),
            .data (rd_vec[i*XLEN +: XLEN])
        );
    end

    assign bus.rd  = rd_vec;
    assign bus.rdy = rdy_q;

endmodule

// File: tb/tb_rf_multiport.sv
// Self-checking bench for rf_multiport (default 32x32, 2 read / 2 write ports).
module tb_rf_multiport;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    rf_multiport_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus ();

    rf_multiport #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        bus.we = we;
        bus.wa = {wa1, wa0};
        bus.wd = {wd1, wd0};
        bus.ra = {ra1, ra0};
    endtask

    // Expects to be called right after a clear starts; checks rdy across the 31 clear edges
    task automatic clear_window(input string name);
        for (int e = 1; e <= 31; e++) begin
            tick();
            chk(name, {31'd0, bus.rdy}, {31'd0, (e == 31)});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.clr_req = 1'b0;
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd31);

        vecs[0] = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0,  32'h0,        5'd6,  5'd0, 32'h0,        32'h0};
        vecs[1] = '{2'b01, 5'd0, 32'h00001234, 5'd0,  32'h0,        5'd5,  5'd0, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{2'b11, 5'd7, 32'hAAAA0000, 5'd7,  32'h5555FFFF, 5'd5,  5'd0, 32'hDEADBEEF, 32'h0};
        vecs[3] = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,        5'd7,  5'd5, 32'h5555FFFF, 32'hDEADBEEF};
        vecs[4] = '{2'b10, 5'd31, 32'hFFFFFFFF, 5'd31, 32'h80000001, 5'd7, 5'd0, 32'h5555FFFF, 32'h0};
        vecs[5] = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,        5'd31, 5'd7, 32'h80000001, 32'h5555FFFF};
        vecs[6] = '{2'b11, 5'd1, 32'h11111111, 5'd2,  32'h22222222, 5'd31, 5'd5, 32'h80000001, 32'hDEADBEEF};
        vecs[7] = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,        5'd1,  5'd2, 32'h11111111, 32'h22222222};

        // Reset held: not ready, reads zero
        repeat (3) tick();
        chk("reset_rdy", {31'd0, bus.rdy}, 32'd0);
        chk("reset_rd0", bus.rd[31:0], 32'd0);
        chk("reset_rd1", bus.rd[63:32], 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 31; e++) begin
            tick();
            chk("por_rdy", {31'd0, bus.rdy}, {31'd0, (e == 31)});
            if (e < 31) begin
                chk("por_rd0", bus.rd[31:0], 32'd0);
                chk("por_rd1", bus.rd[63:32], 32'd0);
            end
        end

        // Table-driven writes/reads; reads show state before this cycle's writes
        for (int v = 0; v < 8; v++) begin
            drive(vecs[v].we, vecs[v].wa0, vecs[v].wd0, vecs[v].wa1, vecs[v].wd1,
                  vecs[v].ra0, vecs[v].ra1);
            #1;
            chk($sformatf("vec%0d_rd0", v), bus.rd[31:0], vecs[v].exp0);
            chk($sformatf("vec%0d_rd1", v), bus.rd[63:32], vecs[v].exp1);
            tick();
        end

        // Same-cycle write/read of x9: bypass-dependent
        drive(2'b01, 5'd9, 32'hCAFEF00D, 5'd0, 32'h0, 5'd9, 5'd0);
        #1;
`ifdef RF_BYPASS_EN
        chk("bypass_same_cycle", bus.rd[31:0], 32'hCAFEF00D);
`else
        chk("nobypass_same_cycle", bus.rd[31:0], 32'h0);
`endif
        tick();
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd0);
        #1;
        chk("x9_after_write", bus.rd[31:0], 32'hCAFEF00D);

        // Fill x1..x31 with their index
        for (int i = 1; i <= 31; i++) begin
            drive(2'b01, 5'(i), 32'(i), 5'd0, 32'h0, 5'd0, 5'd0);
            tick();
        end
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd31);
        #1;
        chk("fill_x3", bus.rd[31:0], 32'd3);
        chk("fill_x31", bus.rd[63:32], 32'd31);

        // Clear request with a concurrent write of x3
        bus.clr_req = 1'b1;
        drive(2'b01, 5'd3, 32'hFF, 5'd0, 32'h0, 5'd3, 5'd31);
        #1;
        chk("clr_req_rdy_before", {31'd0, bus.rdy}, 32'd1);
        tick();
        bus.clr_req = 1'b0;
        chk("clr_req_rdy_after", {31'd0, bus.rdy}, 32'd0);
        for (int e = 1; e <= 31; e++) begin
            // A write attempted mid-clear, after x4 was already swept, must be ignored
            if (e == 10) drive(2'b01, 5'd4, 32'h44, 5'd0, 32'h0, 5'd3, 5'd4);
            else         drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd4);
            #1;
            chk("clr_rd0", bus.rd[31:0], 32'd0);
            chk("clr_rd1", bus.rd[63:32], 32'd0);
            tick();
            chk("clr_rdy", {31'd0, bus.rdy}, {31'd0, (e == 31)});
        end
        for (int i = 1; i <= 31; i++) begin
            drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'(i), 5'd0);
            #1;
            chk($sformatf("after_clr_x%0d", i), bus.rd[31:0], 32'd0);
        end

        // Mid-clear reset: restart needs a full 31 edges
        drive(2'b01, 5'd10, 32'h0000ABCD, 5'd0, 32'h0, 5'd10, 5'd0);
        tick();
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd10, 5'd0);
        #1;
        chk("x10_written", bus.rd[31:0], 32'h0000ABCD);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk("midclr_rdy", {31'd0, bus.rdy}, 32'd0);
        end
        rst_n = 1'b0;
        #1;
        chk("midclr_reset_rdy", {31'd0, bus.rdy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_window("midclr_restart_rdy");
        #1;
        chk("midclr_x10", bus.rd[31:0], 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
